// File: rtl/split_assign_gen.sv
// ---------------------------------------------------------------------------
// split_assign_gen
//
// Stimulus generator for a split_* constraint evaluator. Starting from a seed
// it walks consecutive candidate assignments (seed, seed+1, ... modulo
// 2^VEC_W) and presents one per valid/ready handshake. The evaluator answers
// each accepted candidate with chk_x. The generator counts the candidates it
// issued and the ones that satisfied the evaluator, and it captures the first
// satisfying candidate of the run.
//
// Parameters
//   VEC_W     width of the packed assignment (var_0 at the LSBs), 2..1024
//   CNT_W     width of the candidate limit and of the counters, 2..32
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle run request, honoured only while idle
//   seed       first candidate, sampled on an accepted start
//   limit      number of candidates to issue (0 = none), sampled on start
//   vec_out    current candidate presented to the evaluator
//   vec_valid  vec_out holds a candidate
//   vec_ready  evaluator accepts the candidate this cycle
//   chk_x      evaluator result for vec_out, meaningful on a handshake only
//   busy       run in progress
//   done       one-cycle pulse when a run ends
//   issued     candidates accepted during this run
//   sat_cnt    accepted candidates with chk_x=1 (saturating)
//   first_sat  first satisfying candidate of this run
//   found      first_sat is valid
// ---------------------------------------------------------------------------
module split_assign_gen #(
  parameter int VEC_W = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VEC_W-1:0] seed,
  input  logic [CNT_W-1:0] limit,
  output logic [VEC_W-1:0] vec_out,
  output logic             vec_valid,
  input  logic             vec_ready,
  input  logic             chk_x,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issued,
  output logic [CNT_W-1:0] sat_cnt,
  output logic [VEC_W-1:0] first_sat,
  output logic             found
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] rem;
  logic             hs;
  logic             run_start;
  logic             last_hs;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) r = v;
    else    r = v + CNT_W'(1);
    return r;
  endfunction

  // A start is only accepted from IDLE; in RUN or FIN it is dropped.
  assign run_start = (state == IDLE) && start;
  assign hs        = (state == RUN) && vec_ready;
  // The handshake that consumes the final remaining candidate ends the run.
  assign last_hs   = hs && (rem == CNT_W'(1));

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // ---- next state and outputs ----
  always_comb begin
    state_nx  = state;
    vec_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (limit != '0) ? RUN : FIN;
      end
      RUN: begin
        vec_valid = 1'b1;
        busy      = 1'b1;
        if (last_hs) state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- candidate, remaining count and result registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out   <= '0;
      rem       <= '0;
      issued    <= '0;
      sat_cnt   <= '0;
      first_sat <= '0;
      found     <= 1'b0;
    end else if (run_start) begin
      vec_out   <= seed;
      rem       <= limit;
      issued    <= '0;
      sat_cnt   <= '0;
      first_sat <= '0;
      found     <= 1'b0;
    end else if (hs) begin
      // issued is bounded by limit, so a plain increment cannot overflow.
      issued  <= issued + CNT_W'(1);
      rem     <= rem - CNT_W'(1);
      vec_out <= vec_out + VEC_W'(1);
      if (chk_x) begin
        sat_cnt <= sat_inc(sat_cnt);
        if (!found) begin
          first_sat <= vec_out;
          found     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_split_assign_gen.sv
module tb_split_assign_gen;

  localparam int VW = 64;
  localparam int CW = 16;
  localparam int SVW = 8;
  localparam int SCW = 2;

  logic          clk = 1'b0;
  logic          rst_n;

  // main instance
  logic          start;
  logic [VW-1:0] seed;
  logic [CW-1:0] limit;
  logic [VW-1:0] vec_out;
  logic          vec_valid;
  logic          vec_ready;
  logic          chk_x;
  logic          busy;
  logic          done;
  logic [CW-1:0] issued;
  logic [CW-1:0] sat_cnt;
  logic [VW-1:0] first_sat;
  logic          found;
  int            chk_mode;

  // small-counter instance
  logic           s_start;
  logic [SVW-1:0] s_seed;
  logic [SCW-1:0] s_limit;
  logic [SVW-1:0] s_vec_out;
  logic           s_vec_valid;
  logic           s_vec_ready;
  logic           s_chk_x;
  logic           s_busy;
  logic           s_done;
  logic [SCW-1:0] s_issued;
  logic [SCW-1:0] s_sat_cnt;
  logic [SVW-1:0] s_first_sat;
  logic           s_found;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // chk_x model: 0 = never, 1 = even candidates, 2 = always,
  // 3 = even candidates on handshake, forced high during stalls
  always_comb begin
    case (chk_mode)
      1:       chk_x = ~vec_out[0];
      2:       chk_x = 1'b1;
      3:       chk_x = vec_ready ? ~vec_out[0] : 1'b1;
      default: chk_x = 1'b0;
    endcase
  end

  split_assign_gen #(.VEC_W(VW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .limit(limit),
    .vec_out(vec_out), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .chk_x(chk_x), .busy(busy), .done(done), .issued(issued),
    .sat_cnt(sat_cnt), .first_sat(first_sat), .found(found)
  );

  split_assign_gen #(.VEC_W(SVW), .CNT_W(SCW)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .seed(s_seed), .limit(s_limit),
    .vec_out(s_vec_out), .vec_valid(s_vec_valid), .vec_ready(s_vec_ready),
    .chk_x(s_chk_x), .busy(s_busy), .done(s_done), .issued(s_issued),
    .sat_cnt(s_sat_cnt), .first_sat(s_first_sat), .found(s_found)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [VW-1:0] sd, input logic [CW-1:0] lim);
    seed  = sd;
    limit = lim;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_results(input string tag, input logic [CW-1:0] e_iss,
                               input logic [CW-1:0] e_sat, input logic [VW-1:0] e_first,
                               input logic e_found);
    check({tag, "_issued"},    64'(issued),    64'(e_iss));
    check({tag, "_sat_cnt"},   64'(sat_cnt),   64'(e_sat));
    check({tag, "_first_sat"}, first_sat,      e_first);
    check({tag, "_found"},     64'(found),     64'(e_found));
  endtask

  initial begin
    logic [VW-1:0] exp_v;
    int k;

    rst_n = 1'b0;
    start = 1'b0; seed = '0; limit = '0; vec_ready = 1'b1; chk_mode = 0;
    s_start = 1'b0; s_seed = '0; s_limit = '0; s_vec_ready = 1'b1; s_chk_x = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_vec_out", vec_out, 64'd0);
    check("rst_vec_valid", 64'(vec_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check_results("rst", 0, 0, 0, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_vec_valid", 64'(vec_valid), 64'd0);

    // limit = 0: immediate done, no candidate
    pulse_start(64'd77, 0);
    check("lim0_done", 64'(done), 64'd1);
    check("lim0_valid", 64'(vec_valid), 64'd0);
    check("lim0_busy", 64'(busy), 64'd0);
    check_results("lim0", 0, 0, 0, 1'b0);
    tick();
    check("lim0_done_drop", 64'(done), 64'd0);
    check("lim0_valid_after", 64'(vec_valid), 64'd0);

    // seed 5, limit 4, even candidates satisfy
    chk_mode = 1;
    vec_ready = 1'b1;
    pulse_start(64'd5, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("seq_vec_%0d", i), vec_out, 64'(5 + i));
      check($sformatf("seq_valid_%0d", i), 64'(vec_valid), 64'd1);
      check($sformatf("seq_busy_%0d", i), 64'(busy), 64'd1);
      check($sformatf("seq_done_%0d", i), 64'(done), 64'd0);
      tick();
    end
    check("seq_done", 64'(done), 64'd1);
    check("seq_busy_at_done", 64'(busy), 64'd0);
    check("seq_valid_at_done", 64'(vec_valid), 64'd0);
    check_results("seq", 4, 2, 64'd6, 1'b1);
    tick();
    check("seq_done_drop", 64'(done), 64'd0);
    check_results("seq_hold", 4, 2, 64'd6, 1'b1);

    // Backpressure 1,0,0,1,...; chk_x high during stalls must be ignored
    chk_mode = 3;
    vec_ready = 1'b0;
    pulse_start(64'd5, 4);
    exp_v = 64'd5;
    k = 0;
    while (!done && k < 60) begin
      vec_ready = (k % 3 == 0);
      #1;
      check($sformatf("bp_vec_%0d", k), vec_out, exp_v);
      check($sformatf("bp_valid_%0d", k), 64'(vec_valid), 64'd1);
      if (vec_ready) exp_v = exp_v + 1;
      k++;
      tick();
    end
    vec_ready = 1'b1;
    check("bp_done_reached", 64'(done), 64'd1);
    check("bp_cycles", 64'(k), 64'd10);
    check_results("bp", 4, 2, 64'd6, 1'b1);
    tick();

    // Wrap around all-ones
    chk_mode = 0;
    pulse_start({VW{1'b1}} - 64'd1, 3);
    check("wrap_vec_0", vec_out, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    check("wrap_vec_1", vec_out, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check("wrap_vec_2", vec_out, 64'd0);
    tick();
    check("wrap_done", 64'(done), 64'd1);
    check_results("wrap", 3, 0, 64'd0, 1'b0);
    tick();

    // start pulsed mid-run is ignored
    chk_mode = 2;
    pulse_start(64'd10, 3);
    seed = 64'd100; limit = 1; start = 1'b1;
    check("ign_vec_0", vec_out, 64'd10);
    tick();
    start = 1'b0;
    check("ign_vec_1", vec_out, 64'd11);
    tick();
    check("ign_vec_2", vec_out, 64'd12);
    tick();
    check("ign_done", 64'(done), 64'd1);
    check_results("ign", 3, 3, 64'd10, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fin_start_ignored_busy", 64'(busy), 64'd0);
    check("fin_start_ignored_done", 64'(done), 64'd0);
    check_results("ign_hold", 3, 3, 64'd10, 1'b1);

    // Reset during RUN after 2 handshakes
    pulse_start(64'd20, 5);
    tick(); tick();
    check("mid_vec_before_rst", vec_out, 64'd22);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vec_out", vec_out, 64'd0);
    check("mid_rst_valid", 64'(vec_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check_results("mid_rst", 0, 0, 0, 1'b0);
    tick();
    check("mid_rst_no_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_no_done", 64'(done), 64'd0);
    pulse_start(64'd30, 2);
    check("fresh_vec_0", vec_out, 64'd30);
    tick();
    check("fresh_vec_1", vec_out, 64'd31);
    tick();
    check("fresh_done", 64'(done), 64'd1);
    check_results("fresh", 2, 2, 64'd30, 1'b1);
    tick();

    // CNT_W = 2 instance: limit 3, always satisfied
    s_chk_x = 1'b1;
    s_seed = 8'h10; s_limit = 2'd3; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 10 && !s_done; i++) tick();
    check("s1_done", 64'(s_done), 64'd1);
    check("s1_issued", 64'(s_issued), 64'd3);
    check("s1_sat_cnt", 64'(s_sat_cnt), 64'd3);
    check("s1_first_sat", 64'(s_first_sat), 64'h10);
    check("s1_found", 64'(s_found), 64'd1);
    check("s1_vec_out", 64'(s_vec_out), 64'h13);
    tick();

    // New run clears counters
    s_chk_x = 1'b0;
    s_seed = 8'h40; s_limit = 2'd2; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("s2_cleared_sat", 64'(s_sat_cnt), 64'd0);
    check("s2_cleared_found", 64'(s_found), 64'd0);
    for (int i = 0; i < 10 && !s_done; i++) tick();
    check("s2_done", 64'(s_done), 64'd1);
    check("s2_issued", 64'(s_issued), 64'd2);
    check("s2_sat_cnt", 64'(s_sat_cnt), 64'd0);
    check("s2_first_sat", 64'(s_first_sat), 64'd0);
    check("s2_found", 64'(s_found), 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/split_assign_gen.md
# split_assign_gen

Sequential stimulus generator that drives the packed input vector of a `split_*` constraint evaluator and collects its single-bit result `x`. It enumerates candidate assignments from a seed, presents one per accepted handshake, counts satisfying candidates, and captures the first one. It sits upstream of the evaluator as its transmitter: it produces the assignments the evaluator consumes, and the evaluator's `x` returns to it.

## Interface
- `VEC_W`, 64, width of the packed assignment (concatenation of all evaluator inputs, `var_0` at LSBs); 2..1024
- `CNT_W`, 16, width of candidate limit and counters; 2..32

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle request to begin a run; ignored unless IDLE
- `seed`  in  VEC_W  first candidate; sampled on accepted `start`
- `limit`  in  CNT_W  number of candidates to issue; sampled on accepted `start`; 0 means none
- `vec_out`  out  VEC_W  current candidate to evaluator
- `vec_valid`  out  1  `vec_out` holds a candidate
- `vec_ready`  in  1  evaluator accepts candidate this cycle
- `chk_x`  in  1  evaluator result for `vec_out`, valid when `vec_valid & vec_ready`
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse at end of run
- `issued`  out  CNT_W  candidates accepted this run
- `sat_cnt`  out  CNT_W  accepted candidates with `chk_x=1`
- `first_sat`  out  VEC_W  first satisfying candidate of this run
- `found`  out  1  `first_sat` is valid

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE: on `start`, load `vec_out<=seed` and remaining count `rem<=limit`, then clear `issued`, `sat_cnt`, `found`, and `first_sat`. Go to RUN if `limit!=0`, else FIN.
- RUN: `vec_valid=1`. On handshake (`vec_valid & vec_ready`):
  - `issued+=1`;
  - if `chk_x`: `sat_cnt+=1`; if `!found`, set `first_sat<=vec_out` and `found<=1`;
  - `vec_out<=vec_out+1` modulo 2^VEC_W, so all-ones wraps to zero;
  - `rem-=1`; when `rem` was 1, go to FIN.
- Without a handshake, `vec_out` holds stable and no counters change.
- FIN: assert `done` for one cycle, then go to IDLE. Results hold until the next accepted `start`.
- `sat_cnt` saturates at 2^CNT_W-1. `issued` cannot overflow because it is bounded by `limit`.
- `start` in RUN or FIN is ignored. There is no abort; `rst_n` is the only way to stop a run.
- `chk_x` is ignored whenever there is no handshake.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE. All outputs are 0: `vec_out`, `vec_valid`, `busy`, `done`, `issued`, `sat_cnt`, `first_sat`, `found`.
- Reset mid-run: all state clears immediately and no `done` is produced.
- `start` at edge N gives `vec_valid=1` and `busy=1` from cycle N+1.
- With `vec_ready` held high, one candidate is accepted per cycle. The last handshake at edge M gives `done=1` in cycle M+1 with `busy=0`, and final counters are visible from M+1.
- `limit=0`: `done` pulses in cycle N+1, `vec_valid` never rises, and counters read 0.
- `vec_valid`, once high, does not drop until the final handshake.
- `vec_out` does not change while `vec_valid & !vec_ready`.
- `done` and `busy` are never high together. Minimum spacing between accepted `start`s is `limit+2` cycles.

## Test plan
- Reset then idle: all outputs read 0; `start` with `limit=0` gives a `done` pulse 1 cycle later with no `vec_valid` and counters at 0.
- `seed=5`, `limit=4`, `vec_ready=1`, `chk_x=1` for even `vec_out`: bench sees 5, 6, 7, 8 issued; `issued=4`, `sat_cnt=2`, `first_sat=6`, `found=1`, `done` 5 cycles after `start`.
- Backpressure with `vec_ready` toggling 1,0,0,1,...: `vec_out` stable during stalls; `chk_x` pulses during stalls do not change `sat_cnt`; final counts match the unstalled run.
- Wrap: `seed=2^VEC_W-2`, `limit=3` gives sequence all-ones-minus-1, all-ones, 0; `chk_x=0` throughout gives `found=0`, `sat_cnt=0`.
- `CNT_W=2`, `limit=3`, `chk_x=1` always: `sat_cnt=3`. Repeat across runs: counters clear on each new `start`; `start` pulsed mid-run is ignored.
- `rst_n` dropped during RUN after 2 handshakes: outputs are 0 asynchronously, no `done`; a fresh `start` runs normally.
